// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
//   The serial line is first passed through a synchroniser. A baud counter then
//   samples each bit at its centre. The word, together with its framing and
//   parity flags, is presented on a valid/ready interface.
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous reset, active-high
//   rx_in      - asynchronous serial input, idle high
//   rx_data    - received word, held stable while rx_valid=1
//   rx_valid   - rx_data/frame_err/parity_err are valid
//   rx_ready   - consumer accepts the word when rx_valid && rx_ready
//   frame_err  - a stop bit was sampled low (qualified by rx_valid)
//   parity_err - parity mismatch (qualified by rx_valid, 0 when PARITY=0)
//   overrun    - sticky: a completed frame was dropped while a word was held
//   busy       - receiver is not idle
module uart_rx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  // Returns 1 when the received parity bit does not match the data.
  function automatic logic parity_bad(input logic [DATA_BITS-1:0] data,
                                      input logic                 pbit);
    logic x;
    x = ^{data, pbit};
    if (PARITY == 1) begin
      parity_bad = ~x;
    end else if (PARITY == 2) begin
      parity_bad = x;
    end else begin
      parity_bad = 1'b0;
    end
  endfunction

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_s;
  state_t                 state_r, state_next_s;
  logic [CNT_W-1:0]       cnt_r, cnt_next_s;
  logic [3:0]             bit_r, bit_next_s;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   ferr_r, perr_r, complete_r;
  logic                   mid_s, last_s, frame_bad_s, accept_s;
  logic                   start_s, shift_en_s, par_en_s, stop_en_s, done_s;

  assign rx_s        = sync_r[SYNC_STAGES-1];
  assign mid_s       = (cnt_r == CNT_MID);
  assign last_s      = (cnt_r == CNT_LAST);
  // The stop error includes the sample being taken this cycle.
  assign frame_bad_s = ferr_r | ~rx_s;
  assign accept_s    = rx_valid & rx_ready;

  // Synchroniser chain, preset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], rx_in};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_s == 1'b0) state_next_s = ST_START;
        else              state_next_s = ST_IDLE;
      end
      ST_START: begin
        if (mid_s && rx_s)  state_next_s = ST_IDLE;   // glitch, not a start bit
        else if (mid_s)     state_next_s = ST_DATA;
        else                state_next_s = ST_START;
      end
      ST_DATA: begin
        if (last_s && (bit_r == DATA_LAST)) begin
          state_next_s = (PARITY != 0) ? ST_PARITY : ST_STOP;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (last_s) state_next_s = ST_STOP;
        else        state_next_s = ST_PARITY;
      end
      ST_STOP: begin
        // Leave right after the last stop sample so a back-to-back start is seen.
        if (last_s && (bit_r == STOP_LAST)) begin
          if (frame_bad_s && (shift_r == {DATA_BITS{1'b0}})) state_next_s = ST_BREAK;
          else                                                state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_next_s = ST_IDLE;
        else      state_next_s = ST_BREAK;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs: baud/bit counter updates and datapath strobes.
  always_comb begin
    cnt_next_s = cnt_r + CNT_ONE;
    bit_next_s = bit_r;
    start_s    = 1'b0;
    shift_en_s = 1'b0;
    par_en_s   = 1'b0;
    stop_en_s  = 1'b0;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_next_s = CNT_ZERO;
        bit_next_s = 4'd0;
        start_s    = ~rx_s;
      end
      ST_START: begin
        // After the mid-start sample, every later sample is one full bit later.
        if (mid_s) cnt_next_s = CNT_ZERO;
        else       cnt_next_s = cnt_r + CNT_ONE;
        bit_next_s = 4'd0;
      end
      ST_DATA: begin
        if (last_s) begin
          cnt_next_s = CNT_ZERO;
          shift_en_s = 1'b1;
          if (bit_r == DATA_LAST) bit_next_s = 4'd0;
          else                    bit_next_s = bit_r + 4'd1;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_PARITY: begin
        if (last_s) begin
          cnt_next_s = CNT_ZERO;
          par_en_s   = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (last_s) begin
          cnt_next_s = CNT_ZERO;
          stop_en_s  = 1'b1;
          if (bit_r == STOP_LAST) begin
            done_s     = 1'b1;
            bit_next_s = 4'd0;
          end else begin
            bit_next_s = bit_r + 4'd1;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_BREAK: begin
        cnt_next_s = CNT_ZERO;
        bit_next_s = 4'd0;
      end
      default: begin
        cnt_next_s = CNT_ZERO;
        bit_next_s = 4'd0;
      end
    endcase
  end

  // Frame datapath: counters, shift register, per-frame error accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= CNT_ZERO;
      bit_r      <= 4'd0;
      shift_r    <= {DATA_BITS{1'b0}};
      ferr_r     <= 1'b0;
      perr_r     <= 1'b0;
      complete_r <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cnt_r      <= cnt_next_s;
      bit_r      <= bit_next_s;
      complete_r <= done_s;
      busy       <= (state_next_s != ST_IDLE);
      if (shift_en_s) shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
      // Flags are cleared at the next start, after the completion cycle has used them.
      if (start_s) begin
        ferr_r <= 1'b0;
        perr_r <= 1'b0;
      end else begin
        if (stop_en_s) ferr_r <= frame_bad_s;
        if (par_en_s)  perr_r <= parity_bad(shift_r, rx_s);
      end
    end
  end

  // Holding register, valid/ready handshake and overrun tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= {DATA_BITS{1'b0}};
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (complete_r && (!rx_valid || accept_s)) begin
        rx_data    <= shift_r;
        frame_err  <= ferr_r;
        parity_err <= perr_r;
        rx_valid   <= 1'b1;
      end else if (accept_s) begin
        rx_valid   <= 1'b0;
      end
      if (complete_r && rx_valid && !rx_ready) overrun <= 1'b1;
      else if (accept_s)                       overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed and randomised bench for uart_rx_param.
//   dut0: 8N1, 4 clocks per bit, 2 sync stages.
//   dut1: 8E2, 6 clocks per bit, 3 sync stages.
//   Each expected word is {overrun, frame_err, parity_err, data}. It is computed
//   from the bit pattern that is sent on the line.
module tb_uart_rx_param;
  localparam int CPB0 = 4;
  localparam int CPB1 = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rx0, rx1, rdy0, rdy1;
  logic [7:0] data0, data1;
  logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;

  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB0), .PARITY(0), .STOP_BITS(1),
                  .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .rx_in(rx0), .rx_data(data0), .rx_valid(v0),
    .rx_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(busy0));

  uart_rx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB1), .PARITY(2), .STOP_BITS(2),
                  .SYNC_STAGES(3)) dut1 (
    .clk(clk), .rst(rst), .rx_in(rx1), .rx_data(data1), .rx_valid(v1),
    .rx_ready(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(busy1));

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] got0[$], got1[$], exp0[$], exp1[$];

  // Record every accepted word, away from the active edge.
  always @(negedge clk) begin
    if (v0 === 1'b1 && rdy0 === 1'b1) got0.push_back({ov0, fe0, pe0, data0});
    if (v1 === 1'b1 && rdy1 === 1'b1) got1.push_back({ov1, fe1, pe1, data1});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int d, input logic b);
    if (d == 0) rx0 = b;
    else        rx1 = b;
  endtask

  function automatic int cpb(input int d);
    return (d == 0) ? CPB0 : CPB1;
  endfunction

  // Reference: even parity on dut1 fails when the total count of ones is odd.
  function automatic logic [10:0] model(input int d, input logic [7:0] data,
                                        input logic pbit, input logic [1:0] stops,
                                        input logic ov);
    int   ones;
    logic fe, pe;
    ones = $countones(data) + int'(pbit);
    pe   = (d == 1) ? ((ones % 2) != 0) : 1'b0;
    fe   = (d == 0) ? (stops[0] == 1'b0) : (stops != 2'b11);
    return {ov, fe, pe, data};
  endfunction

  task automatic send(input int d, input logic [7:0] data, input logic pbit,
                      input logic [1:0] stops);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (d == 1) bits.push_back(pbit);
    bits.push_back(stops[0]);
    if (d == 1) bits.push_back(stops[1]);
    foreach (bits[i]) begin
      drive(d, bits[i]);
      tick(cpb(d));
    end
    drive(d, 1'b1);
  endtask

  task automatic exp_word(input int d, input logic [10:0] w);
    if (d == 0) exp0.push_back(w);
    else        exp1.push_back(w);
  endtask

  // Send a frame, queue its expected word, then let the line idle.
  task automatic frame(input int d, input logic [7:0] data, input logic pbit,
                       input logic [1:0] stops);
    send(d, data, pbit, stops);
    exp_word(d, model(d, data, pbit, stops, 1'b0));
    tick(3 * cpb(d));
  endtask

  task automatic drain(input int d, input string tag);
    logic [10:0] g, e;
    if (d == 0) begin
      check({tag, "_count"}, got0.size(), exp0.size());
      while (got0.size() > 0 && exp0.size() > 0) begin
        g = got0.pop_front();
        e = exp0.pop_front();
        check(tag, g, e);
      end
      got0.delete();
      exp0.delete();
    end else begin
      check({tag, "_count"}, got1.size(), exp1.size());
      while (got1.size() > 0 && exp1.size() > 0) begin
        g = got1.pop_front();
        e = exp1.pop_front();
        check(tag, g, e);
      end
      got1.delete();
      exp1.delete();
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [1:0] st;
    logic       pb;
    rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1;
    tick(5);
    check("reset0", {data0, v0, fe0, pe0, ov0, busy0}, 32'd0);
    check("reset1", {data1, v1, fe1, pe1, ov1, busy1}, 32'd0);
    rst = 1'b0;
    tick(5);

    // Nominal 8N1 word.
    frame(0, 8'hD3, 1'b0, 2'b11);
    drain(0, "nominal");

    // Even parity: correct parity bit, then a wrong one.
    frame(1, 8'hD3, 1'b1, 2'b11);
    frame(1, 8'hD3, 1'b0, 2'b11);
    drain(1, "parity");

    // Framing errors: low stop bit on each receiver.
    frame(0, 8'h55, 1'b0, 2'b10);
    drain(0, "frame0");
    frame(1, 8'h3C, 1'b0, 2'b01);
    drain(1, "frame1");

    // Break: line low for three frame times, busy held throughout.
    rx0 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(10);
      check("break_busy", busy0, 1'b1);
    end
    exp_word(0, model(0, 8'h00, 1'b0, 2'b00, 1'b0));
    rx0 = 1'b1;
    tick(6);
    check("break_idle", busy0, 1'b0);
    drain(0, "break");

    // One-cycle glitch: seen as a start edge, then rejected at mid-bit.
    rx0 = 1'b0;
    tick(1);
    rx0 = 1'b1;
    tick(2);
    check("glitch_seen", busy0, 1'b1);
    tick(20);
    check("glitch_idle", busy0, 1'b0);
    drain(0, "glitch");

    // Overrun: back-to-back frames with the consumer stalled.
    rdy0 = 1'b0;
    send(0, 8'h11, 1'b0, 2'b11);
    send(0, 8'h22, 1'b0, 2'b11);
    tick(12);
    check("ovr_valid", v0, 1'b1);
    check("ovr_hold", data0, 8'h11);
    check("ovr_flag", ov0, 1'b1);
    exp_word(0, model(0, 8'h11, 1'b0, 2'b11, 1'b1));
    rdy0 = 1'b1;
    tick(1);
    check("ovr_clear", {v0, ov0}, 2'b00);
    frame(0, 8'h33, 1'b0, 2'b11);
    drain(0, "overrun");

    // Reset in the middle of a frame, with a word still held.
    rdy0 = 1'b0;
    send(0, 8'h5A, 1'b0, 2'b11);
    tick(12);
    rx0 = 1'b0;
    tick(4 * CPB0);
    check("pre_rst", {v0, busy0, data0}, {1'b1, 1'b1, 8'h5A});
    rst = 1'b1;
    rx0 = 1'b1;
    tick(1);
    check("mid_rst", {data0, v0, fe0, pe0, ov0, busy0}, 32'd0);
    rst = 1'b0;
    rdy0 = 1'b1;
    tick(8);
    frame(0, 8'hA5, 1'b0, 2'b11);
    drain(0, "after_rst");

    // Randomised frames against the reference model.
    for (int i = 0; i < 8; i++) begin
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      frame(0, b, 1'b0, st);
      b  = 8'($urandom_range(0, 255));
      pb = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      frame(1, b, pb, st);
    end
    drain(0, "rand0");
    drain(1, "rand1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
